// File: rtl/mem_responder.sv
// Word-addressed memory responder with a fixed-latency, stall-aware read pipeline.
// Define MEM_RESP_REPORT_EN to build the debug report printer and its cycle counter.
module mem_responder #(
    parameter int CORE           = 0,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_BITS   = 20,
    parameter int MEM_DEPTH_BITS = 12,
    parameter int LATENCY        = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDRESS_BITS-1:0] address,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    m_stall,
    input  logic                    report,
    output logic [ADDRESS_BITS-1:0] out_addr,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    valid,
    output logic                    ready
);

    localparam int DEPTH = 1 << MEM_DEPTH_BITS;

    typedef enum logic {
        S_RESET,
        S_RUN
    } state_t;

    state_t state;
    logic   ready_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_RESET;
            ready_q <= 1'b0;
        end else begin
            unique case (state)
                S_RESET: begin
                    state   <= S_RUN;
                    ready_q <= 1'b1;
                end
                S_RUN: begin
                    state   <= S_RUN;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= S_RUN;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready = ready_q;

    logic                      accept;
    logic                      out_of_range;
    logic                      wr_en;
    logic                      rd_en;
    logic [MEM_DEPTH_BITS-1:0] idx;
    logic [DATA_WIDTH-1:0]     rd_word;

    assign accept       = (read | write) & ready_q & ~m_stall;
    assign out_of_range = (address >> MEM_DEPTH_BITS) != '0;
    assign idx          = address[MEM_DEPTH_BITS-1:0];
    // Write wins a read/write collision; the read is dropped without a response.
    assign wr_en        = accept & write & ~out_of_range;
    assign rd_en        = accept & read & ~write;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[idx] <= in_data;
        end
    end

    assign rd_word = out_of_range ? '0 : mem[idx];

    logic [LATENCY-1:0]      stg_valid;
    logic [ADDRESS_BITS-1:0] stg_addr [LATENCY];
    logic [DATA_WIDTH-1:0]   stg_data [LATENCY];

    always_ff @(posedge clock) begin
        if (reset) begin
            stg_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stg_addr[i] <= '0;
                stg_data[i] <= '0;
            end
        end else if (!m_stall) begin
            stg_valid[0] <= rd_en;
            if (rd_en) begin
                stg_addr[0] <= address;
                stg_data[0] <= rd_word;
            end
            for (int i = 1; i < LATENCY; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_addr[i]  <= stg_addr[i-1];
                stg_data[i]  <= stg_data[i-1];
            end
        end
    end

    assign valid    = stg_valid[LATENCY-1];
    assign out_addr = stg_addr[LATENCY-1];
    assign out_data = stg_data[LATENCY-1];

`ifdef MEM_RESP_REPORT_EN
    logic [31:0] cycle_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
        end
        if (report) begin
            $display("core %0d cycle %0d: rd=%b wr=%b addr=%h din=%h stall=%b rdy=%b vld=%b oaddr=%h odata=%h",
                     CORE, cycle_count, read, write, address, in_data,
                     m_stall, ready, valid, out_addr, out_data);
        end
    end
`else
    logic        unused_report;
    logic [31:0] unused_core;

    assign unused_report = report;
    assign unused_core   = CORE;
`endif

endmodule
